// File: rtl/keypad_scan_encoder.sv
// 4x4 active-low keypad scanner: column scan, tick-based debounce, row*4+col encoding,
// and one fixed-length write-enable window per accepted press.
module keypad_scan_encoder #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int VALID_CYCLES   = 300000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [3:0] iROW,
  output logic [3:0] oCOL,
  output logic [3:0] oKEY,
  output logic       oKEY_VALID,
  output logic       oBUSY
);

  localparam int DIV_W = $clog2(SCAN_DIV + 1);
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam int VAL_W = $clog2(VALID_CYCLES + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, REPORT, RELEASE} state_t;

  state_t     state, state_next;
  logic [3:0] row_meta, row_s;
  logic [1:0] col, col_next;
  logic [DIV_W-1:0] div, div_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [VAL_W-1:0] vcnt, vcnt_next;
  logic [3:0] code, code_next;
  logic [3:0] pattern, pattern_next;
  logic [3:0] key_next;
  logic       valid_next;
  logic       tick;
  logic [1:0] low_row;

  assign tick  = (div == DIV_W'(SCAN_DIV - 1));
  assign oCOL  = ~(4'b0001 << col);
  assign oBUSY = (state != SCAN);

  // Lowest-index pressed row wins when several rows share the driven column.
  always_comb begin
    low_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_s[r]) low_row = 2'(r);
    end
  end

  always_comb begin
    state_next   = state;
    col_next     = col;
    div_next     = tick ? '0 : div + 1'b1;
    cnt_next     = cnt;
    vcnt_next    = vcnt;
    code_next    = code;
    pattern_next = pattern;
    key_next     = oKEY;
    valid_next   = oKEY_VALID;
    case (state)
      SCAN: begin
        if (tick) begin
          if (row_s == 4'hF) begin
            col_next = col + 2'd1;
          end else begin
            code_next    = {low_row, col};
            pattern_next = row_s;
            cnt_next     = CNT_W'(1);
            state_next   = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (row_s == pattern) begin
            if (cnt >= CNT_W'(DEBOUNCE_TICKS - 1)) begin
              cnt_next   = '0;
              vcnt_next  = '0;
              key_next   = code;
              valid_next = 1'b1;
              state_next = REPORT;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end else begin
            cnt_next   = '0;
            col_next   = col + 2'd1;
            state_next = SCAN;
          end
        end
      end
      REPORT: begin
        if (vcnt == VAL_W'(VALID_CYCLES - 1)) begin
          vcnt_next  = '0;
          cnt_next   = '0;
          valid_next = 1'b0;
          state_next = RELEASE;
        end else begin
          vcnt_next = vcnt + 1'b1;
        end
      end
      RELEASE: begin
        // The column stays frozen so the held key keeps pulling its row low until let go.
        if (tick) begin
          if (row_s == 4'hF) begin
            if (cnt >= CNT_W'(DEBOUNCE_TICKS - 1)) begin
              cnt_next   = '0;
              col_next   = col + 2'd1;
              state_next = SCAN;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end else begin
            cnt_next = '0;
          end
        end
      end
      default: state_next = SCAN;
    endcase
    if ((state_next != state) || (col_next != col)) div_next = '0;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      row_meta   <= 4'hF;
      row_s      <= 4'hF;
      state      <= SCAN;
      col        <= 2'd0;
      div        <= '0;
      cnt        <= '0;
      vcnt       <= '0;
      code       <= 4'd0;
      pattern    <= 4'hF;
      oKEY       <= 4'd0;
      oKEY_VALID <= 1'b0;
    end else begin
      row_meta   <= iROW;
      row_s      <= row_meta;
      state      <= state_next;
      col        <= col_next;
      div        <= div_next;
      cnt        <= cnt_next;
      vcnt       <= vcnt_next;
      code       <= code_next;
      pattern    <= pattern_next;
      oKEY       <= key_next;
      oKEY_VALID <= valid_next;
    end
  end

endmodule
